// File: rtl/rst_seq_if.sv
// Handshake bundle between the reset sequencer and its surroundings.
// master drives the request/ack side; slave is the sequencer itself.
interface rst_seq_if #(
  parameter int N_DOM = 4,
  parameter int DLY_W = 8
);
  localparam int KW = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  logic                   sw_rst_req_i;
  logic [N_DOM*DLY_W-1:0] dly_i;
  logic [N_DOM-1:0]       ack_i;
  logic [N_DOM-1:0]       rst_n_o;
  logic                   busy_o;
  logic                   done_o;
  logic                   err_o;
  logic [KW-1:0]          err_dom_o;

  modport master (
    output sw_rst_req_i, dly_i, ack_i,
    input  rst_n_o, busy_o, done_o, err_o, err_dom_o
  );

  modport slave (
    input  sw_rst_req_i, dly_i, ack_i,
    output rst_n_o, busy_o, done_o, err_o, err_dom_o
  );
endinterface

// File: rtl/rst_seq.sv
// Multi-domain reset sequencer: hold all domains, then release them one at a
// time in index order, each after its own delay and gated by its acknowledge.
module rst_seq #(
  parameter int N_DOM    = 4,
  parameter int DLY_W    = 8,
  parameter int HOLD_CYC = 16,
  parameter int TO_CYC   = 1024
) (
  input logic       clk_i,
  input logic       rst_n_i,
  rst_seq_if.slave  bus
);
  localparam int KW = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int TW = $clog2(TO_CYC + 1);

  typedef enum logic [2:0] {S_HOLD, S_DLY, S_ACK, S_RUN, S_ERR} state_t;

  state_t                        state;
  logic [KW-1:0]                 k;
  logic [KW-1:0]                 k_nxt;
  logic [HW-1:0]                 hcnt;
  logic [DLY_W-1:0]              dcnt;
  logic [TW-1:0]                 tcnt;
  logic [N_DOM-1:0][DLY_W-1:0]   dly_arr;
  logic                          last_dom;

  for (genvar g = 0; g < N_DOM; g++) begin : g_dly
    assign dly_arr[g] = bus.dly_i[g*DLY_W +: DLY_W];
  end

  assign k_nxt    = k + 1'b1;
  assign last_dom = (k == KW'(N_DOM - 1));

  // Outputs are updated on the same edge as the state they describe.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= S_HOLD;
      k             <= '0;
      hcnt          <= '0;
      dcnt          <= '0;
      tcnt          <= '0;
      bus.rst_n_o   <= '0;
      bus.busy_o    <= 1'b1;
      bus.done_o    <= 1'b0;
      bus.err_o     <= 1'b0;
      bus.err_dom_o <= '0;
    end else if (bus.sw_rst_req_i) begin
      state         <= S_HOLD;
      k             <= '0;
      hcnt          <= '0;
      dcnt          <= '0;
      tcnt          <= '0;
      bus.rst_n_o   <= '0;
      bus.busy_o    <= 1'b1;
      bus.done_o    <= 1'b0;
      bus.err_o     <= 1'b0;
      bus.err_dom_o <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (hcnt == HW'(HOLD_CYC - 1)) begin
            state <= S_DLY;
            k     <= '0;
            hcnt  <= '0;
            dcnt  <= dly_arr[0];
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        S_DLY: begin
          // Delay is latched at stage entry, so d=0 still spends one cycle here.
          if (dcnt == '0) begin
            bus.rst_n_o[k] <= 1'b1;
            state          <= S_ACK;
            tcnt           <= '0;
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end
        S_ACK: begin
          if (bus.ack_i[k]) begin
            if (last_dom) begin
              state      <= S_RUN;
              bus.busy_o <= 1'b0;
              bus.done_o <= 1'b1;
            end else begin
              state <= S_DLY;
              k     <= k_nxt;
              dcnt  <= dly_arr[k_nxt];
            end
          end else if (tcnt == TW'(TO_CYC - 1)) begin
            state         <= S_ERR;
            bus.busy_o    <= 1'b0;
            bus.err_o     <= 1'b1;
            bus.err_dom_o <= k;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RUN, S_ERR: begin
        end
        default: state <= S_HOLD;
      endcase
    end
  end
endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter N_DOM, default 4, number of reset domains sequenced (1..8).
REQ-002 Parameter DLY_W, default 8, width of each per-domain release delay field.
REQ-003 Parameter HOLD_CYC, default 16, minimum cycles all domains are held in reset (>=1).
REQ-004 Parameter TO_CYC, default 1024, cycles allowed for a domain acknowledge before timeout (>=1).
REQ-005 clk_i  in  1  clock; all logic is single-clock, rising-edge.
REQ-006 rst_n_i  in  1  asynchronous, active-low reset, already deassertion-synchronized to clk_i upstream.
REQ-007 sw_rst_req_i  in  1  software reset request, single-cycle pulse.
REQ-008 dly_i  in  N_DOM*DLY_W  per-domain release delay; field k = bits [k*DLY_W +: DLY_W].
REQ-009 ack_i  in  N_DOM  per-domain ready acknowledge, level, already synchronous to clk_i.
REQ-010 rst_n_o  out  N_DOM  per-domain active-low reset, registered, glitch-free.
REQ-011 busy_o  out  1  high while a sequence is in progress (any state except RUN, ERR).
REQ-012 done_o  out  1  high in RUN (all domains released and acknowledged).
REQ-013 err_o  out  1  high in ERR (acknowledge timeout).
REQ-014 err_dom_o  out  $clog2(N_DOM) (min 1)  index of the domain that timed out; valid while err_o=1.

Function
REQ-015 The FSM shall have states HOLD, DLY, ACK, RUN, ERR plus a stage index k (0..N_DOM-1).
REQ-016 HOLD: all rst_n_o=0; a counter shall run for exactly HOLD_CYC cycles, then go to DLY with k=0.
REQ-017 On DLY entry, dly_i field k shall be sampled into a down-counter; later dly_i changes shall not affect that stage.
REQ-018 DLY: rst_n_o[k] shall rise on the edge ending the (d+1)-th DLY cycle, d = sampled delay (d=0 -> one cycle); the FSM shall enter ACK on that same edge.
REQ-019 ACK: the first cycle with ack_i[k]=1 shall advance to DLY with k+1, or to RUN if k=N_DOM-1; the ACK-exit edge is the next edge.
REQ-020 ACK: if ack_i[k] stays 0 for TO_CYC consecutive cycles, the FSM shall enter ERR with err_dom_o=k.
REQ-021 Domains shall be released strictly in index order; rst_n_o[j] for j>k shall remain 0 until stage j releases.
REQ-022 Once released within a sequence, rst_n_o[k] shall stay 1 until the next HOLD, even if ack_i[k] later falls.
REQ-023 ERR: already-released domains keep rst_n_o=1; unreleased domains stay 0; err_o=1 until sw_rst_req_i.
REQ-024 sw_rst_req_i=1 in any state shall enter HOLD on the next edge, drive all rst_n_o=0, clear err_o, restart the hold counter.
REQ-025 sw_rst_req_i while already in HOLD shall restart the HOLD_CYC count.
REQ-026 Counters shall not wrap; the timeout counter shall be sized for TO_CYC, the delay counter for DLY_W.
REQ-027 busy_o, done_o, err_o shall be registered, mutually exclusive, and update on the same edge as the state change.

Reset
REQ-028 While rst_n_i=0: state=HOLD, k=0, counters=0, rst_n_o=all 0, busy_o=1, done_o=0, err_o=0, err_dom_o=0.
REQ-029 Assertion of rst_n_i mid-sequence shall force all rst_n_o=0 immediately (asynchronous, no clock needed).
REQ-030 After rst_n_i deassertion, the first HOLD cycle is the first rising edge with rst_n_i=1.

Verification
REQ-031 N_DOM=4, HOLD_CYC=16, dly={3,0,5,2} (dom0..3), ack_i tied 1 -> rst_n_o[0] rises 20 cycles after reset release, then dom1 +2, dom2 +7, dom3 +4 cycles, then done_o=1 one cycle later.
REQ-032 ack_i[2] held 0, TO_CYC=1024 -> exactly 1024 ACK cycles after rst_n_o[2] rises, err_o=1, err_dom_o=2, rst_n_o=4'b0111, busy_o=0.
REQ-033 From ERR, pulse sw_rst_req_i with ack_i[2] then 1 -> next edge rst_n_o=0, err_o=0, busy_o=1; full sequence completes to done_o=1.
REQ-034 Change dly_i field 1 from 0 to 200 while stage 1 is in DLY -> release timing uses 0; field 1 change before stage 1 entry uses 200.
REQ-035 Assert rst_n_i low mid-DLY of stage 2 -> rst_n_o=0 without a clock edge; release reruns HOLD from count 0.
REQ-036 sw_rst_req_i pulsed on cycle 10 of HOLD -> HOLD lasts 16 cycles from that pulse (26 total), all rst_n_o stay 0 throughout.
